// File: rtl/aes_round_sequencer.sv
// Iterative AES encryption controller.
// Owns the 128-bit cipher state, the latched cipher key and the round counter,
// and drives one shared combinational full-round datapath plus an external
// round-key source. One block in flight at a time; valid/ready on both sides.
module aes_round_sequencer #(
   parameter int NR    = 10,
   parameter int RND_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [127:0]     plaintext,
   input  logic [127:0]     cipher_key,
   output logic [127:0]     key_out,
   output logic [RND_W-1:0] rk_index,
   input  logic [127:0]     rk_in,
   output logic [127:0]     dp_state,
   output logic             dp_final,
   input  logic [127:0]     dp_result,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [127:0]     ciphertext,
   output logic             busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ROUND = 2'd1,
      FINAL = 2'd2,
      DONE  = 2'd3
   } seqState_t;

   // Round index of the last MixColumns round and of the final round.
   localparam logic [RND_W-1:0] LAST_MIX_RND = RND_W'(NR - 1);
   localparam logic [RND_W-1:0] FINAL_RND    = RND_W'(NR);

   seqState_t        curState, nextState;
   logic [127:0]     stateReg;
   logic [127:0]     keyReg;
   logic [RND_W-1:0] roundCnt;
   logic             accept;

   // The round key is consumed by the external datapath; the controller only
   // publishes the index it wants, so rk_in is deliberately not read here.
   logic unusedRkIn;
   assign unusedRkIn = ^rk_in;

   assign accept = in_valid & in_ready;

   // FSM state register; reset abandons any block in flight.
   always_ff @(posedge clk) begin
      if (reset) curState <= IDLE;
      else       curState <= nextState;
   end

   // Next-state logic: NR-1 MixColumns rounds, one final round, then hold for the sink.
   always_comb begin
      nextState = curState;
      case (curState)
         IDLE:  if (accept) nextState = (NR == 1) ? FINAL : ROUND;
         ROUND: if (roundCnt == LAST_MIX_RND) nextState = FINAL;
         FINAL: nextState = DONE;
         DONE:  if (out_ready) nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   // Cipher state, key latch and round counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         stateReg <= '0;
         keyReg   <= '0;
         roundCnt <= '0;
      end else begin
         case (curState)
            IDLE: begin
               // Initial AddRoundKey happens on the way in; round key 0 is the cipher key.
               if (accept) begin
                  stateReg <= plaintext ^ cipher_key;
                  keyReg   <= cipher_key;
                  roundCnt <= RND_W'(1);
               end
            end
            ROUND: begin
               stateReg <= dp_result;
               roundCnt <= roundCnt + 1'b1;
            end
            FINAL: begin
               stateReg <= dp_result;
               roundCnt <= '0;
            end
            default: ;  // DONE holds the result until the sink takes it
         endcase
      end
   end

   // Outputs depend on FSM state only, never on the incoming handshakes.
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      dp_final  = 1'b0;
      rk_index  = '0;
      case (curState)
         IDLE:  in_ready = 1'b1;
         ROUND: begin
            busy     = 1'b1;
            rk_index = roundCnt;
         end
         FINAL: begin
            busy     = 1'b1;
            dp_final = 1'b1;
            rk_index = FINAL_RND;
         end
         DONE:  out_valid = 1'b1;
         default: ;
      endcase
   end

   // The datapath always sees the registered state, and the result is the state itself.
   assign dp_state   = stateReg;
   assign ciphertext = stateReg;
   assign key_out    = keyReg;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Directed bench for aes_round_sequencer: a real AES round/key-schedule model
// or a simple additive stub stands in for the external datapath.
module tb_aes_round_sequencer;

   localparam int NR    = 10;
   localparam int RND_W = 4;

   logic             clk = 1'b0;
   logic             reset;
   logic             in_valid;
   logic             in_ready;
   logic [127:0]     plaintext;
   logic [127:0]     cipher_key;
   logic [127:0]     key_out;
   logic [RND_W-1:0] rk_index;
   logic [127:0]     rkIn;
   logic [127:0]     dp_state;
   logic             dp_final;
   logic [127:0]     dpResult;
   logic             out_valid;
   logic             out_ready;
   logic [127:0]     ciphertext;
   logic             busy;

   logic stubMode;
   int   total = 0;
   int   bad   = 0;

   aes_round_sequencer #(.NR(NR), .RND_W(RND_W)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready),
      .plaintext(plaintext), .cipher_key(cipher_key),
      .key_out(key_out), .rk_index(rk_index), .rk_in(rkIn),
      .dp_state(dp_state), .dp_final(dp_final), .dp_result(dpResult),
      .out_valid(out_valid), .out_ready(out_ready),
      .ciphertext(ciphertext), .busy(busy)
   );

   always #5 clk = ~clk;

   // ---------------- AES reference model ----------------
   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         a = xtime(a);
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rol8(input logic [7:0] b, input int n);
      logic [15:0] d;
      d = {b, b} << n;
      return d[15:8];
   endfunction

   // S-box from first principles: GF(2^8) inverse (a^254) plus affine map.
   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] sq = a;
      logic [7:0] r  = 8'h01;
      for (int i = 1; i < 8; i++) begin
         sq = gmul(sq, sq);
         r  = gmul(r, sq);
      end
      return r ^ rol8(r, 1) ^ rol8(r, 2) ^ rol8(r, 3) ^ rol8(r, 4) ^ 8'h63;
   endfunction

   function automatic logic [127:0] aesRound(input logic [127:0] s, input logic [127:0] rk,
                                             input logic fin);
      logic [7:0]   t[16];
      logic [7:0]   a0, a1, a2, a3;
      logic [127:0] o;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            t[4*c+r] = sbox(s[127-8*(4*((c+r)%4)+r) -: 8]);
      for (int c = 0; c < 4; c++) begin
         a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
         if (!fin) begin
            t[4*c]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            t[4*c+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            t[4*c+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            t[4*c+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
         end
      end
      for (int i = 0; i < 16; i++) o[127-8*i -: 8] = t[i];
      return o ^ rk;
   endfunction

   function automatic logic [127:0] roundKey(input logic [127:0] key, input int idx);
      logic [31:0] w0, w1, w2, w3, tw;
      logic [7:0]  rcon = 8'h01;
      {w0, w1, w2, w3} = key;
      for (int k = 1; k <= idx && k <= 10; k++) begin
         tw = {w3[23:0], w3[31:24]};
         tw = {sbox(tw[31:24]) ^ rcon, sbox(tw[23:16]), sbox(tw[15:8]), sbox(tw[7:0])};
         w0 = w0 ^ tw; w1 = w1 ^ w0; w2 = w2 ^ w1; w3 = w3 ^ w2;
         rcon = xtime(rcon);
      end
      return {w0, w1, w2, w3};
   endfunction

   // External key source and datapath: real AES or additive stub.
   always_comb begin
      rkIn = stubMode ? 128'(rk_index) : roundKey(key_out, int'(rk_index));
   end
   always_comb begin
      dpResult = stubMode ? dp_state + rkIn : aesRound(dp_state, rkIn, dp_final);
   end

   // ---------------- checking helpers ----------------
   task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Wait (bounded) for in_ready, then present one block for a single accept edge.
   task automatic startBlock(input string nm, input logic [127:0] key, input logic [127:0] pt);
      int n = 0;
      while (!in_ready && n < 40) begin tick(); n++; end
      check({nm, " ready"}, 128'(in_ready), 128'd1);
      cipher_key = key;
      plaintext  = pt;
      in_valid   = 1'b1;
      tick();
      in_valid   = 1'b0;
   endtask

   // Count edges until out_valid; optionally trace the round-key index sequence.
   task automatic waitValid(input string nm, input bit trace, output int n);
      n = 0;
      while (!out_valid && n < 40) begin
         if (trace) begin
            check($sformatf("%s rk_index c%0d", nm, n), 128'(rk_index), 128'(n + 1));
            check($sformatf("%s dp_final c%0d", nm, n), 128'(dp_final), 128'(n == NR - 1));
         end
         tick();
         n++;
      end
   endtask

   task automatic drain(input string nm);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check({nm, " out_valid after hs"}, 128'(out_valid), 128'd0);
      check({nm, " in_ready after hs"}, 128'(in_ready), 128'd1);
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      string        name;
      logic         stub;
      logic [127:0] key;
      logic [127:0] pt;
      logic [127:0] ct;
   } vec_t;

   localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;

   vec_t vecs[3];

   // Back-to-back monitor (sampled mid-cycle, i.e. what the next edge will see).
   bit           monOn = 1'b0;
   int           cyc = 0;
   int           accQ[$];
   logic [127:0] outQ[$];
   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (monOn && !reset && in_valid && in_ready)  accQ.push_back(cyc);
      if (monOn && !reset && out_valid && out_ready) outQ.push_back(ciphertext);
   end

   initial begin
      int           n;
      logic [127:0] held;

      vecs[0] = '{"fips_c1", 1'b0, KEY_C1, PT_C1, CT_C1};
      vecs[1] = '{"fips_b",  1'b0, KEY_B,  PT_B,  CT_B};
      vecs[2] = '{"stub",    1'b1, KEY_C1, PT_C1, (PT_C1 ^ KEY_C1) + 128'd55};

      stubMode = 1'b0; reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      plaintext = '0; cipher_key = '0;
      tick(); tick();
      reset = 1'b0;
      check("rst in_ready",   128'(in_ready),  128'd1);
      check("rst out_valid",  128'(out_valid), 128'd0);
      check("rst busy",       128'(busy),      128'd0);
      check("rst dp_final",   128'(dp_final),  128'd0);
      check("rst rk_index",   128'(rk_index),  128'd0);
      check("rst ciphertext", ciphertext,      128'd0);
      check("rst key_out",    key_out,         128'd0);
      check("rst dp_state",   dp_state,        128'd0);

      // Table: latency, result, key latch.
      for (int i = 0; i < 3; i++) begin
         stubMode = vecs[i].stub;
         startBlock(vecs[i].name, vecs[i].key, vecs[i].pt);
         check({vecs[i].name, " busy"}, 128'(busy), 128'd1);
         waitValid(vecs[i].name, vecs[i].stub, n);
         check({vecs[i].name, " latency"}, 128'(n), 128'(NR));
         check({vecs[i].name, " ciphertext"}, ciphertext, vecs[i].ct);
         check({vecs[i].name, " key_out"}, key_out, vecs[i].key);
         check({vecs[i].name, " busy done"}, 128'(busy), 128'd0);
         drain(vecs[i].name);
      end
      stubMode = 1'b0;

      // Backpressure: result and flags hold for 7 stalled cycles.
      startBlock("bp", KEY_C1, PT_C1);
      waitValid("bp", 1'b0, n);
      check("bp latency", 128'(n), 128'(NR));
      held = ciphertext;
      for (int i = 0; i < 7; i++) begin
         check($sformatf("bp out_valid s%0d", i), 128'(out_valid), 128'd1);
         check($sformatf("bp ciphertext s%0d", i), ciphertext, CT_C1);
         check($sformatf("bp stable s%0d", i), ciphertext, held);
         check($sformatf("bp in_ready s%0d", i), 128'(in_ready), 128'd0);
         tick();
      end
      drain("bp");

      // in_valid stays high with changing data while busy: only the first block counts.
      cipher_key = KEY_C1; plaintext = PT_C1; in_valid = 1'b1;
      tick();
      n = 0;
      while (!out_valid && n < 40) begin
         plaintext  = {$urandom, $urandom, $urandom, $urandom};
         cipher_key = {$urandom, $urandom, $urandom, $urandom};
         tick();
         n++;
      end
      in_valid = 1'b0;
      check("hold latency", 128'(n), 128'(NR));
      check("hold ciphertext", ciphertext, CT_C1);
      check("hold key_out", key_out, KEY_C1);
      drain("hold");
      startBlock("hold2", KEY_B, PT_B);
      waitValid("hold2", 1'b0, n);
      check("hold2 ciphertext", ciphertext, CT_B);
      drain("hold2");

      // Reset during round 5 abandons the block.
      startBlock("mrst", KEY_C1, PT_C1);
      for (int i = 0; i < 4; i++) tick();
      check("mrst rk_index pre", 128'(rk_index), 128'd5);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("mrst in_ready",  128'(in_ready),  128'd1);
      check("mrst out_valid", 128'(out_valid), 128'd0);
      check("mrst rk_index",  128'(rk_index),  128'd0);
      check("mrst busy",      128'(busy),      128'd0);
      check("mrst key_out",   key_out,         128'd0);
      for (int i = 0; i < 12; i++) begin
         if (out_valid) check("mrst ghost output", 128'(out_valid), 128'd0);
         tick();
      end
      startBlock("mrst2", KEY_C1, PT_C1);
      waitValid("mrst2", 1'b0, n);
      check("mrst2 latency", 128'(n), 128'(NR));
      check("mrst2 ciphertext", ciphertext, CT_C1);
      drain("mrst2");

      // Back-to-back with out_ready tied high.
      monOn = 1'b1;
      out_ready = 1'b1;
      cipher_key = KEY_C1; plaintext = PT_C1; in_valid = 1'b1;
      n = 0;
      while (outQ.size() < 2 && n < 60) begin
         tick();
         n++;
         if (accQ.size() == 1) begin cipher_key = KEY_B; plaintext = PT_B; end
         if (accQ.size() >= 2) in_valid = 1'b0;
      end
      in_valid = 1'b0; out_ready = 1'b0; monOn = 1'b0;
      check("b2b accepts", 128'(accQ.size()), 128'd2);
      check("b2b outputs", 128'(outQ.size()), 128'd2);
      if (accQ.size() >= 2) check("b2b spacing", 128'(accQ[1] - accQ[0]), 128'(NR + 2));
      if (outQ.size() >= 2) begin
         check("b2b ct0", outQ[0], CT_C1);
         check("b2b ct1", outQ[1], CT_B);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
